// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointer,
// full/almost-full flags, write-side fill level and sticky overflow.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH     = 3,
  parameter int ALMOST_FULL_TH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   R2W_PTR_GRAY,
  input  logic                  OVF_CLR,
  output logic                  W_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   W_PTR_GRAY,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  OVERFLOW
);

  localparam int AW = ADDR_WIDTH;
  // Full when write Gray equals read Gray with its two MSBs inverted
  localparam logic [AW:0] TOP2 = (AW+1)'(3) << (AW-1);
  localparam logic [AW:0] AF_TH = (AW+1)'(ALMOST_FULL_TH);

  logic [AW:0] r_wbin;
  logic [AW:0] r_wgray;
  logic        r_full;
  logic        r_af;
  logic [AW:0] r_level;
  logic        r_ovf;

  logic        w_inc_ok;
  logic        w_ovf_set;
  logic [AW:0] w_rbin;
  logic [AW:0] w_wbin_next;
  logic [AW:0] w_wgray_next;
  logic [AW:0] w_level_next;
  logic        w_full_next;
  logic        w_af_next;

  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= AW; i++) begin
      w_rbin[i] = ^(R2W_PTR_GRAY >> i);
    end
  end

  assign w_inc_ok     = W_INC & ~r_full;
  assign w_ovf_set    = W_INC & r_full;
  assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_inc_ok};
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
  assign w_level_next = w_wbin_next - w_rbin;
  assign w_full_next  = (w_wgray_next == (R2W_PTR_GRAY ^ TOP2));
  assign w_af_next    = (w_level_next >= AF_TH);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
      r_af    <= w_af_next;
      r_level <= w_level_next;
      r_ovf   <= w_ovf_set | (r_ovf & ~OVF_CLR);
    end
  end

  assign W_EN        = w_inc_ok;
  assign W_ADDR      = r_wbin[AW-1:0];
  assign W_PTR_GRAY  = r_wgray;
  assign FULL        = r_full;
  assign ALMOST_FULL = r_af;
  assign W_LEVEL     = r_level;
  assign OVERFLOW    = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl (ADDR_WIDTH=3) with
// extra instances probing ALMOST_FULL_TH=8 and ALMOST_FULL_TH=1.
module tb_fifo_wr_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       W_INC = 1'b0;
  logic [3:0] R2W_PTR_GRAY = '0;
  logic       OVF_CLR = 1'b0;

  logic       W_EN, FULL, ALMOST_FULL, OVERFLOW;
  logic [2:0] W_ADDR;
  logic [3:0] W_PTR_GRAY, W_LEVEL;

  logic       en8, full8, af8, ovf8;
  logic [2:0] addr8;
  logic [3:0] gray8, lvl8;
  logic       en1, full1, af1, ovf1;
  logic [2:0] addr1;
  logic [3:0] gray1, lvl1;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  fifo_wr_ctrl #(.ADDR_WIDTH(3), .ALMOST_FULL_TH(6)) u_dut (
    .CLK(CLK), .RST(RST), .W_INC(W_INC),
    .R2W_PTR_GRAY(R2W_PTR_GRAY), .OVF_CLR(OVF_CLR),
    .W_EN(W_EN), .W_ADDR(W_ADDR), .W_PTR_GRAY(W_PTR_GRAY),
    .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
    .W_LEVEL(W_LEVEL), .OVERFLOW(OVERFLOW)
  );

  fifo_wr_ctrl #(.ADDR_WIDTH(3), .ALMOST_FULL_TH(8)) u_af8 (
    .CLK(CLK), .RST(RST), .W_INC(W_INC),
    .R2W_PTR_GRAY(R2W_PTR_GRAY), .OVF_CLR(OVF_CLR),
    .W_EN(en8), .W_ADDR(addr8), .W_PTR_GRAY(gray8),
    .FULL(full8), .ALMOST_FULL(af8),
    .W_LEVEL(lvl8), .OVERFLOW(ovf8)
  );

  fifo_wr_ctrl #(.ADDR_WIDTH(3), .ALMOST_FULL_TH(1)) u_af1 (
    .CLK(CLK), .RST(RST), .W_INC(W_INC),
    .R2W_PTR_GRAY(R2W_PTR_GRAY), .OVF_CLR(OVF_CLR),
    .W_EN(en1), .W_ADDR(addr1), .W_PTR_GRAY(gray1),
    .FULL(full1), .ALMOST_FULL(af1),
    .W_LEVEL(lvl1), .OVERFLOW(ovf1)
  );

  typedef struct packed {
    logic [3:0] gray;
    logic [2:0] addr;
    logic       full;
    logic       af;
    logic       af8;
    logic       af1;
    logic [3:0] lvl;
    logic       ovf;
    logic       acc;
  } exp_t;

  exp_t sb_q[$];

  logic [3:0] m_wbin = '0;
  logic [3:0] m_rbin = '0;
  logic [3:0] m_gray = '0;
  logic       m_full = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       wrapped = 1'b0;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic inc, input logic [3:0] rg,
                      input logic clr);
    exp_t       e;
    logic [3:0] nb;
    logic [3:0] lvl;
    W_INC        = inc;
    R2W_PTR_GRAY = rg;
    OVF_CLR      = clr;
    e.acc  = inc & ~m_full;
    nb     = m_wbin + {3'b000, e.acc};
    lvl    = nb - g2b(rg);
    e.gray = b2g(nb);
    e.addr = nb[2:0];
    e.lvl  = lvl;
    e.full = (lvl == 4'd8);
    e.af   = (lvl >= 4'd6);
    e.af8  = (lvl >= 4'd8);
    e.af1  = (lvl >= 4'd1);
    e.ovf  = (inc & m_full) | (m_ovf & ~clr);
    sb_q.push_back(e);
    #1;
    chk("w_en", W_EN, e.acc);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    chk("gray", W_PTR_GRAY, e.gray);
    chk("addr", W_ADDR, e.addr);
    chk("full", FULL, e.full);
    chk("almost_full", ALMOST_FULL, e.af);
    chk("af_th8", af8, e.af8);
    chk("af_th1", af1, e.af1);
    chk("level", W_LEVEL, e.lvl);
    chk("overflow", OVERFLOW, e.ovf);
    chk("gray_1bit", $countones(m_gray ^ W_PTR_GRAY), e.acc);
    if (m_wbin == 4'hF && nb == 4'h0) wrapped = 1'b1;
    m_wbin = nb;
    m_gray = e.gray;
    m_full = e.full;
    m_ovf  = e.ovf;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gray"}, W_PTR_GRAY, 0);
    chk({tag, "_addr"}, W_ADDR, 0);
    chk({tag, "_full"}, FULL, 0);
    chk({tag, "_af"}, ALMOST_FULL, 0);
    chk({tag, "_level"}, W_LEVEL, 0);
    chk({tag, "_ovf"}, OVERFLOW, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gseq [8];
    gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    repeat (2) @(posedge CLK);
    #1;
    chk_zero("rst_init");
    RST = 1'b1;

    repeat (3) step(1'b1, 4'h0, 1'b0);
    // Drop reset mid-cycle and look before the next clock edge
    #2 RST = 1'b0;
    #1 chk_zero("rst_async");
    @(posedge CLK);
    #1 chk_zero("rst_hold");
    RST    = 1'b1;
    m_wbin = '0;
    m_gray = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;

    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'h0, 1'b0);
      chk("fill_seq", W_PTR_GRAY, gseq[k]);
      chk("fill_lvl", W_LEVEL, k + 1);
    end
    chk("first_full", FULL, 1);
    chk("af8_with_full", af8, 1);

    repeat (2) step(1'b1, 4'h0, 1'b0);
    chk("ovf_hold_gray", W_PTR_GRAY, 4'hC);
    chk("ovf_set", OVERFLOW, 1);
    step(1'b0, 4'h0, 1'b1);
    chk("ovf_clr", OVERFLOW, 0);
    step(1'b1, 4'h0, 1'b1);
    chk("ovf_set_wins", OVERFLOW, 1);

    step(1'b0, 4'h1, 1'b1);
    chk("read_unfull", FULL, 0);
    chk("read_level", W_LEVEL, 7);
    step(1'b1, 4'h1, 1'b0);
    chk("refill_full", FULL, 1);
    chk("refill_gray", W_PTR_GRAY, 4'hD);

    m_rbin = 4'h1;
    for (int c = 0; c < 60; c++) begin
      if ($urandom_range(0, 1) == 1 && m_rbin != m_wbin)
        m_rbin = m_rbin + 4'h1;
      step($urandom_range(0, 3) != 0, b2g(m_rbin), 1'b0);
    end
    chk("wrap_seen", wrapped, 1);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
